// File: rtl/bpred_pkg.sv
// Shared types for the branch-predictor performance monitor: FSM state
// encoding and read-select codes.
package bpred_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ALARM = 2'd2
    } bpState_t;

    localparam logic [1:0] RD_BRANCH  = 2'b00;
    localparam logic [1:0] RD_MISPRED = 2'b01;
    localparam logic [1:0] RD_TAKEN   = 2'b10;
    localparam logic [1:0] RD_STATUS  = 2'b11;

endpackage

// File: rtl/bpred_evtstage.sv
// One pipeline stage of {Branch, Wrong, Taken}: flush clears, stall holds,
// and flush wins when both are asserted.
module bpred_evtstage (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [2:0] evtIn,
    output logic [2:0] evtOut
);

    always_ff @(posedge clk) begin
        if (!reset)      evtOut <= 3'b000;
        else if (flush)  evtOut <= 3'b000;
        else if (!stall) evtOut <= evtIn;
    end

endmodule

// File: rtl/bpred_perfmon.sv
// Branch-predictor performance monitor: global commit counters plus a
// windowed misprediction-rate alarm.
//
//   state | meaning
//   IDLE  | monitor off, window counters held at 0
//   COUNT | accumulating committed branches into the current window
//   ALARM | window exceeded threshold, waiting for AlarmAck
module bpred_perfmon
    import bpred_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int WINDOW = 16,
    parameter int THRESH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            StallW,
    input  logic            FlushM,
    input  logic            FlushW,
    input  logic            BranchE,
    input  logic            BPDirWrongE,
    input  logic            PCSrcE,
    input  logic            Enable,
    input  logic            AlarmAck,
    input  logic            ClearCnt,
    input  logic [1:0]      RdSel,
    output logic [XLEN-1:0] RdData,
    output logic            MispredAlarm
);

    localparam int WCW = $clog2(WINDOW) + 1;
    localparam int SW  = 2 + 2 * WCW;

    logic [2:0] evtE, evtM, evtW;
    logic       commit, wrongW, takenW;

    assign evtE = {BranchE, BPDirWrongE, PCSrcE};

    bpred_evtstage uStageM (
        .clk(clk), .reset(reset), .stall(StallM), .flush(FlushM),
        .evtIn(evtE), .evtOut(evtM)
    );

    bpred_evtstage uStageW (
        .clk(clk), .reset(reset), .stall(StallW), .flush(FlushW),
        .evtIn(evtM), .evtOut(evtW)
    );

    // A stalled W holds its event without committing, so it commits once on release.
    assign commit = evtW[2] & ~StallW & ~FlushW;
    assign wrongW = evtW[1];
    assign takenW = evtW[0];

    logic [XLEN-1:0] branchCnt, mispredCnt, takenCnt;

    always_ff @(posedge clk) begin
        if (!reset || ClearCnt) begin
            branchCnt  <= '0;
            mispredCnt <= '0;
            takenCnt   <= '0;
        end else if (commit) begin
            branchCnt  <= branchCnt + {{(XLEN-1){1'b0}}, 1'b1};
            mispredCnt <= mispredCnt + {{(XLEN-1){1'b0}}, wrongW};
            takenCnt   <= takenCnt + {{(XLEN-1){1'b0}}, takenW};
        end
    end

    bpState_t       state, stateNext;
    logic [WCW-1:0] winBr, winBrNext, winMiss, winMissNext;
    logic [WCW-1:0] winBrInc, winMissInc;

    assign winBrInc   = winBr + {{(WCW-1){1'b0}}, 1'b1};
    assign winMissInc = winMiss + {{(WCW-1){1'b0}}, wrongW};

    always_comb begin
        stateNext   = state;
        winBrNext   = winBr;
        winMissNext = winMiss;
        if (!Enable) begin
            stateNext   = IDLE;
            winBrNext   = '0;
            winMissNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext   = COUNT;
                    winBrNext   = '0;
                    winMissNext = '0;
                end
                COUNT: begin
                    if (commit) begin
                        if (winBrInc == WCW'(WINDOW)) begin
                            stateNext   = (winMissInc >= WCW'(THRESH)) ? ALARM : COUNT;
                            winBrNext   = '0;
                            winMissNext = '0;
                        end else begin
                            winBrNext   = winBrInc;
                            winMissNext = winMissInc;
                        end
                    end
                end
                ALARM: begin
                    winBrNext   = '0;
                    winMissNext = '0;
                    if (AlarmAck) stateNext = COUNT;
                end
                default: begin
                    stateNext   = IDLE;
                    winBrNext   = '0;
                    winMissNext = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            winBr        <= '0;
            winMiss      <= '0;
            MispredAlarm <= 1'b0;
        end else begin
            state        <= stateNext;
            winBr        <= winBrNext;
            winMiss      <= winMissNext;
            MispredAlarm <= (stateNext == ALARM);
        end
    end

    logic [SW-1:0] statusWord;
    assign statusWord = {state, winMiss, winBr};

    always_comb begin
        RdData = '0;
        case (RdSel)
            RD_BRANCH:  RdData = branchCnt;
            RD_MISPRED: RdData = mispredCnt;
            RD_TAKEN:   RdData = takenCnt;
            RD_STATUS:  RdData = XLEN'(statusWord);
            default:    RdData = '0;
        endcase
    end

endmodule

// File: tb/tb_bpred_perfmon.sv
// Directed boundary cases plus randomized traffic against a behavioural
// model of the monitor, compared on every falling clock edge.
module tb_bpred_perfmon;

    localparam int XLEN = 12;
    localparam int WIN  = 16;
    localparam int THR  = 4;
    localparam int MASK = (1 << XLEN) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            StallM, StallW, FlushM, FlushW;
    logic            BranchE, BPDirWrongE, PCSrcE;
    logic            Enable, AlarmAck, ClearCnt;
    logic [1:0]      RdSel;
    logic [XLEN-1:0] RdData;
    logic            MispredAlarm;

    int passCnt  = 0;
    int totalCnt = 0;
    bit checkOn  = 0;

    bpred_perfmon #(.XLEN(XLEN), .WINDOW(WIN), .THRESH(THR)) dut (
        .clk(clk), .reset(reset),
        .StallM(StallM), .StallW(StallW), .FlushM(FlushM), .FlushW(FlushW),
        .BranchE(BranchE), .BPDirWrongE(BPDirWrongE), .PCSrcE(PCSrcE),
        .Enable(Enable), .AlarmAck(AlarmAck), .ClearCnt(ClearCnt),
        .RdSel(RdSel), .RdData(RdData), .MispredAlarm(MispredAlarm)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain integers for counters, window and state
    // (0 idle, 1 counting, 2 alarm), and the two in-flight pipeline slots.
    int       mBr = 0, mMis = 0, mTak = 0;
    int       mSt = 0, mWb = 0, mWm = 0;
    bit [2:0] pM = 0, pW = 0;

    always @(posedge clk) begin : model
        bit       cm;
        bit [2:0] nM, nW;
        int       nBr, nMis, nTak, nSt, nWb, nWm;
        if (!reset) begin
            mBr <= 0; mMis <= 0; mTak <= 0;
            mSt <= 0; mWb <= 0; mWm <= 0;
            pM <= 0; pW <= 0;
        end else begin
            cm = pW[2] && !StallW && !FlushW;
            nBr = mBr; nMis = mMis; nTak = mTak;
            if (ClearCnt) begin
                nBr = 0; nMis = 0; nTak = 0;
            end else if (cm) begin
                nBr  = (mBr + 1) & MASK;
                nMis = (mMis + pW[1]) & MASK;
                nTak = (mTak + pW[0]) & MASK;
            end
            nSt = mSt; nWb = mWb; nWm = mWm;
            if (!Enable) begin
                nSt = 0; nWb = 0; nWm = 0;
            end else if (mSt == 0) begin
                nSt = 1; nWb = 0; nWm = 0;
            end else if (mSt == 1) begin
                if (cm) begin
                    nWb = mWb + 1;
                    nWm = mWm + pW[1];
                    if (nWb == WIN) begin
                        nSt = (nWm >= THR) ? 2 : 1;
                        nWb = 0; nWm = 0;
                    end
                end
            end else begin
                nWb = 0; nWm = 0;
                if (AlarmAck) nSt = 1;
            end
            nW = FlushW ? 3'b000 : (StallW ? pW : pM);
            nM = FlushM ? 3'b000 : (StallM ? pM : {BranchE, BPDirWrongE, PCSrcE});
            mBr <= nBr; mMis <= nMis; mTak <= nTak;
            mSt <= nSt; mWb <= nWb; mWm <= nWm;
            pM <= nM; pW <= nW;
        end
    end

    function automatic int expRd(input logic [1:0] sel);
        case (sel)
            2'b00:   return mBr;
            2'b01:   return mMis;
            2'b10:   return mTak;
            default: return (mSt << 10) | (mWm << 5) | mWb;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            check("model_rddata", int'(RdData), expRd(RdSel));
            check("model_alarm", int'(MispredAlarm), (mSt == 2) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] sel, output int v);
        RdSel = sel;
        #1;
        v = int'(RdData);
    endtask

    task automatic read3(input string name, input int eb, input int em, input int et);
        int v;
        peek(2'b00, v); check({name, "_branch"}, v, eb);
        peek(2'b01, v); check({name, "_mispred"}, v, em);
        peek(2'b10, v); check({name, "_taken"}, v, et);
    endtask

    task automatic setE(input logic b, input logic w, input logic t);
        BranchE = b; BPDirWrongE = w; PCSrcE = t;
    endtask

    task automatic runWindow(input int nWrong);
        for (int i = 0; i < WIN; i++) begin
            setE(1'b1, i < nWrong, 1'b0);
            tick();
        end
        setE(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int v;
        reset = 1'b0;
        StallM = 0; StallW = 0; FlushM = 0; FlushW = 0;
        setE(1'b0, 1'b0, 1'b0);
        Enable = 0; AlarmAck = 0; ClearCnt = 0; RdSel = 2'b00;
        tick();
        tick();
        checkOn = 1;
        read3("reset", 0, 0, 0);
        peek(2'b11, v); check("reset_status", v, 0);
        check("reset_alarm", int'(MispredAlarm), 0);
        reset = 1'b1;

        // 10 branches, first 3 wrong, last 6 taken.
        for (int i = 0; i < 10; i++) begin
            setE(1'b1, i < 3, i >= 4);
            tick();
        end
        setE(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        read3("count10", 10, 3, 6);

        // Wrong branch held in W for three stalled cycles.
        setE(1'b1, 1'b1, 1'b0);
        tick();
        setE(1'b0, 1'b0, 1'b0);
        tick();
        StallM = 1; StallW = 1;
        tick(); tick(); tick();
        StallM = 0; StallW = 0;
        tick();
        tick();
        read3("stallw", 11, 4, 6);

        // Branch squashed on its way into M.
        setE(1'b1, 1'b1, 1'b1);
        FlushM = 1;
        tick();
        setE(1'b0, 1'b0, 1'b0);
        FlushM = 0;
        tick(); tick(); tick();
        read3("flushm", 11, 4, 6);

        // Clear on the same edge as a commit.
        setE(1'b1, 1'b1, 1'b1);
        tick();
        setE(1'b0, 1'b0, 1'b0);
        tick();
        ClearCnt = 1;
        tick();
        ClearCnt = 0;
        read3("clear_commit", 0, 0, 0);

        // Misprediction counter wrap.
        for (int i = 0; i < MASK; i++) begin
            setE(1'b1, 1'b1, 1'b0);
            tick();
        end
        setE(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        peek(2'b01, v); check("mispred_max", v, MASK);
        setE(1'b1, 1'b1, 1'b0);
        tick();
        setE(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        peek(2'b01, v); check("mispred_wrap", v, 0);

        // Window with 4 wrong -> alarm the cycle after the 16th commit.
        Enable = 1;
        tick();
        peek(2'b11, v); check("enter_count", v, 1024);
        runWindow(4);
        tick();
        peek(2'b11, v); check("win15_status", v, 1024 + (4 << 5) + 15);
        check("win15_alarm", int'(MispredAlarm), 0);
        tick();
        peek(2'b11, v); check("win16_status", v, 2048);
        check("win16_alarm", int'(MispredAlarm), 1);
        AlarmAck = 1;
        tick();
        AlarmAck = 0;
        peek(2'b11, v); check("ack_status", v, 1024);
        check("ack_alarm", int'(MispredAlarm), 0);

        // Window with 3 wrong -> no alarm.
        runWindow(3);
        tick();
        peek(2'b11, v); check("below15_status", v, 1024 + (3 << 5) + 15);
        tick();
        peek(2'b11, v); check("below16_status", v, 1024);
        check("below16_alarm", int'(MispredAlarm), 0);

        // Disable together with acknowledge while alarmed.
        runWindow(5);
        tick();
        tick();
        check("realarm", int'(MispredAlarm), 1);
        Enable = 0;
        AlarmAck = 1;
        tick();
        AlarmAck = 0;
        peek(2'b11, v); check("disable_ack_status", v, 0);
        check("disable_ack_alarm", int'(MispredAlarm), 0);

        // Reset in the middle of a window with events in flight.
        Enable = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            setE(1'b1, 1'b1, 1'b1);
            tick();
        end
        setE(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        read3("midreset", 0, 0, 0);
        tick();
        peek(2'b11, v); check("midreset_status", v, 0);
        check("midreset_alarm", int'(MispredAlarm), 0);
        reset = 1'b1;
        tick(); tick(); tick();
        read3("midreset_drain", 0, 0, 0);

        // Randomized traffic; every cycle is compared against the model.
        for (int i = 0; i < 4000; i++) begin
            BranchE     = ($urandom_range(0, 1) == 1);
            BPDirWrongE = ($urandom_range(0, 3) == 0);
            PCSrcE      = ($urandom_range(0, 1) == 1);
            StallM      = ($urandom_range(0, 9) == 0);
            StallW      = ($urandom_range(0, 9) == 0);
            FlushM      = ($urandom_range(0, 19) == 0);
            FlushW      = ($urandom_range(0, 19) == 0);
            Enable      = ($urandom_range(0, 49) != 0);
            AlarmAck    = ($urandom_range(0, 9) == 0);
            ClearCnt    = ($urandom_range(0, 99) == 0);
            reset       = ($urandom_range(0, 299) != 0);
            RdSel       = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b1;
        setE(1'b0, 1'b0, 1'b0);
        StallM = 0; StallW = 0; FlushM = 0; FlushW = 0;
        AlarmAck = 0; ClearCnt = 0;
        tick();
        tick();
        @(negedge clk);
        #1;
        checkOn = 0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/bpred_perfmon.md
BPRED_PERFMON -- requirements
Module: bpred_perfmon

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, counter and read-data width; WINDOW, 16, committed branches per evaluation window (power of 2, >=2); THRESH, 4, mispredictions per window that raise the alarm (1..WINDOW).
REQ-002 Ports (name direction width meaning):
- clk in 1: the single clock.
- reset in 1: synchronous, active-low.
- StallM in 1, StallW in 1: pipeline stalls.
- FlushM in 1, FlushW in 1: pipeline flushes.
- BranchE in 1: conditional branch in Execute.
- BPDirWrongE in 1: direction mispredicted in Execute.
- PCSrcE in 1: branch resolved taken.
- Enable in 1: window monitor enable.
- AlarmAck in 1: alarm acknowledge.
- ClearCnt in 1: clear all counters.
- RdSel in 2: read select.
- RdData out XLEN: selected read value.
- MispredAlarm out 1: misprediction-rate alarm.

Function
REQ-003 SHALL carry {Branch, Wrong, Taken} from E to M, and from M to W, in registers; each stage is cleared by its Flush and held by its Stall; flush takes priority over stall.
REQ-004 Commit SHALL be BranchW & ~StallW & ~FlushW; an event commits at most once, even across multi-cycle W stalls.
REQ-005 On commit, BranchCnt SHALL increment by 1, MispredCnt by WrongW, and TakenCnt by TakenW; all are XLEN wide and wrap from 2^XLEN-1 to 0.
REQ-006 ClearCnt SHALL zero BranchCnt, MispredCnt and TakenCnt on the next edge; it wins over a same-cycle commit, so the result is 0.
REQ-007 Global counters SHALL count independently of Enable and FSM state.
REQ-008 RdData SHALL be combinational from registered state:
- 00: BranchCnt.
- 01: MispredCnt.
- 10: TakenCnt.
- 11: zero-extended {State[1:0], WinMiss, WinBr}.
REQ-009 Window counters WinBr and WinMiss SHALL each be $clog2(WINDOW)+1 bits wide.
REQ-010 FSM states SHALL be IDLE, COUNT and ALARM.
REQ-011 IDLE: WinBr and WinMiss are held at 0; when Enable=1 the FSM goes to COUNT next cycle.
REQ-012 COUNT: on commit, WinBr+=1 and WinMiss+=WrongW.
REQ-013 COUNT, window end: when a commit makes WinBr reach WINDOW, the FSM SHALL evaluate WinMiss including the current event.
- If WinMiss >= THRESH: go to ALARM.
- Otherwise: stay in COUNT.
- In both cases, both window counters reset to 0.
REQ-014 ALARM: MispredAlarm=1 and window counters are held at 0; commits are not counted into the window.
- AlarmAck=1 goes to COUNT next cycle.
REQ-015 Enable=0 in any state SHALL force IDLE next cycle and clear the window counters; this takes priority over AlarmAck and over window end.
REQ-016 MispredAlarm SHALL be a registered output, equal to (State==ALARM).
- It asserts on the cycle after the window-ending commit edge.
REQ-017 ClearCnt SHALL NOT affect the FSM or the window counters.

Reset
REQ-018 With reset=0 at a clk edge:
- All pipeline, counter and window registers become 0.
- State becomes IDLE.
- MispredAlarm=0, and RdData reads 0 for every RdSel.
REQ-019 Reset asserted mid-window or in ALARM SHALL abandon the window; in-flight M/W events are discarded.

Structure
REQ-020 The bpred_pkg package SHALL hold the FSM state enum (IDLE=0, COUNT=1, ALARM=2) and the RdSel encodings.
REQ-021 One sub-module, bpred_evtstage, SHALL implement a single flushable, stallable 3-bit event register; it is instantiated twice, for M and W.

Verification
REQ-022 Counting: 10 branches, 3 wrong, 6 taken, no stalls -> RdSel 00/01/10 read 10/3/6, 2 cycles after the last E event.
REQ-023 Stall/flush: a wrong branch held 3 cycles by StallW -> MispredCnt increments by exactly 1; a branch flushed by FlushM -> no counter changes.
REQ-024 Window alarm (WINDOW=16, THRESH=4):
- Enable=1, 16 commits with 4 wrong -> MispredAlarm=1 the cycle after the 16th commit.
- AlarmAck -> MispredAlarm=0 next cycle, State=COUNT.
REQ-025 Below threshold: 16 commits with 3 wrong -> no alarm; WinBr=0 and WinMiss=0 afterwards, still COUNT.
REQ-026 Boundaries, each a separate check:
- MispredCnt preset to 2^XLEN-1 plus one wrong commit -> MispredCnt=0.
- ClearCnt together with a commit -> all counters 0.
- Enable=0 together with AlarmAck in ALARM -> IDLE.
- reset=0 mid-window -> all outputs 0.
